sdram_host_bridge: RTL and testbench

//   Host-side front end for sdram_controller. Accepts read/write requests on a valid/ready port
//   and queues them in a small FIFO. Issues one command at a time on the controller's
//   rd_enable/wr_enable/busy interface and returns a one-cycle response per request.
//   The controller samples enables only in IDLE (not in INIT or REFRESH), so this block holds the

---
 rtl/sdram_host_bridge.sv | 167 ++++++++++++++++
 tb/tb_sdram_host_bridge.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_host_bridge.sv
// sdram_host_bridge: host request FIFO and single-command issue FSM in front
// of sdram_controller. Optional issue watchdog enabled by SDRAM_BRIDGE_TIMEOUT_EN.
module sdram_host_bridge #(
  parameter int HADDR_WIDTH    = 24,
  parameter int FIFO_DEPTH     = 4,
  parameter int FIFO_AW        = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [HADDR_WIDTH-1:0] req_addr,
  input  logic [15:0]            req_wdata,
  output logic                   rsp_valid,
  output logic                   rsp_we,
  output logic [15:0]            rsp_rdata,
  output logic                   rsp_err,
  output logic [FIFO_AW:0]       fifo_level,
  output logic [HADDR_WIDTH-1:0] haddr,
  output logic [15:0]            data_input,
  output logic                   rd_enable,
  output logic                   wr_enable,
  input  logic                   busy,
  input  logic [15:0]            data_output
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  localparam int EW = 1 + HADDR_WIDTH + 16;

  state_t state, next_state;

  logic [EW-1:0]      fifo_mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   count;
  logic               full, empty, push, pop;
  logic               done, tmo_fire;
  logic               cur_we;
  logic [EW-1:0]      head;

  assign full       = (count == (FIFO_AW+1)'(FIFO_DEPTH));
  assign empty      = (count == '0);
  assign req_ready  = !full;
  assign push       = req_valid && !full;
  assign fifo_level = count;
  assign head       = fifo_mem[rd_ptr];

  // Queue storage; no reset needed, validity tracked by count
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {req_we, req_addr, req_wdata};
  end

  // Queue pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (FIFO_AW+1)'(1);
        2'b01:   count <= count - (FIFO_AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef SDRAM_BRIDGE_TIMEOUT_EN
  localparam int TW = ($clog2(TIMEOUT_CYCLES+1) > 8) ? $clog2(TIMEOUT_CYCLES+1) : 8;
  logic [TW-1:0] tmo_cnt;

  // Watchdog counts cycles spent in S_ISSUE, cleared when a new command is popped
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   tmo_cnt <= '0;
    else if (pop)              tmo_cnt <= '0;
    else if (state == S_ISSUE) tmo_cnt <= tmo_cnt + TW'(1);
  end

  assign tmo_fire = (state == S_ISSUE) && !busy && (tmo_cnt == TW'(TIMEOUT_CYCLES-1));
`else
  assign tmo_fire = 1'b0;
  assign rsp_err  = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // Next-state and control strobes
  always_comb begin
    next_state = state;
    pop        = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          next_state = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (busy)          next_state = S_WAIT;
        else if (tmo_fire) next_state = S_IDLE;
      end
      S_WAIT: begin
        if (!busy) begin
          done       = 1'b1;
          next_state = S_IDLE;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Command and response registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      haddr      <= '0;
      data_input <= '0;
      rd_enable  <= 1'b0;
      wr_enable  <= 1'b0;
      cur_we     <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_we     <= 1'b0;
      rsp_rdata  <= '0;
`ifdef SDRAM_BRIDGE_TIMEOUT_EN
      rsp_err    <= 1'b0;
`endif
    end else begin
      rsp_valid <= 1'b0;
`ifdef SDRAM_BRIDGE_TIMEOUT_EN
      rsp_err   <= 1'b0;
`endif
      if (pop) begin
        cur_we     <= head[EW-1];
        haddr      <= head[EW-2:16];
        data_input <= head[15:0];
        wr_enable  <= head[EW-1];
        rd_enable  <= !head[EW-1];
      end
      // Enable stays up through controller INIT/REFRESH; only busy or the watchdog drops it
      if ((state == S_ISSUE) && (busy || tmo_fire)) begin
        rd_enable <= 1'b0;
        wr_enable <= 1'b0;
      end
      if (tmo_fire) begin
        rsp_valid <= 1'b1;
        rsp_we    <= cur_we;
`ifdef SDRAM_BRIDGE_TIMEOUT_EN
        rsp_err   <= 1'b1;
`endif
      end
      if (done) begin
        rsp_valid <= 1'b1;
        rsp_we    <= cur_we;
        if (!cur_we) rsp_rdata <= data_output;
      end
    end
  end

endmodule

// File: tb/tb_sdram_host_bridge.sv
// Directed bench for sdram_host_bridge with a behavioural controller model
// (INIT, IDLE, REFRESH, READ, WRITE; enables sampled only in IDLE).
module tb_sdram_host_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_we = 1'b0;
  logic [23:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic        req_ready, rsp_valid, rsp_we, rsp_err;
  logic [15:0] rsp_rdata;
  logic [2:0]  fifo_level;
  logic [23:0] haddr;
  logic [15:0] data_input, data_output;
  logic        rd_enable, wr_enable, busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sdram_host_bridge #(
    .HADDR_WIDTH(24), .FIFO_DEPTH(4), .FIFO_AW(2), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_we(rsp_we), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .fifo_level(fifo_level),
    .haddr(haddr), .data_input(data_input),
    .rd_enable(rd_enable), .wr_enable(wr_enable),
    .busy(busy), .data_output(data_output)
  );

  // ---------------- controller model ----------------
  typedef enum {C_INIT, C_IDLE, C_REF, C_RD, C_WR} cst_t;
  cst_t        cst;
  int          ccnt;
  logic [7:0]  caddr;
  logic [15:0] mem [256];
  int          rd_count, wr_count;
  int          ref_req = 0;
  int          ref_ack;
  logic        dead = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cst <= C_INIT; ccnt <= 20; busy <= 1'b0; data_output <= '0;
      caddr <= '0; ref_ack <= ref_req;
      rd_count <= 0; wr_count <= 0;
    end else begin
      case (cst)
        C_INIT: if (ccnt == 0) cst <= C_IDLE; else ccnt <= ccnt - 1;
        C_IDLE: begin
          if (ref_req != ref_ack) begin
            ref_ack <= ref_req; cst <= C_REF; ccnt <= 30;
          end else if (!dead && rd_enable) begin
            cst <= C_RD; ccnt <= 3; busy <= 1'b1; caddr <= haddr[7:0];
            rd_count <= rd_count + 1;
          end else if (!dead && wr_enable) begin
            cst <= C_WR; ccnt <= 3; busy <= 1'b1;
            mem[haddr[7:0]] <= data_input;
            wr_count <= wr_count + 1;
          end
        end
        C_REF: if (ccnt == 0) cst <= C_IDLE; else ccnt <= ccnt - 1;
        C_RD: if (ccnt == 0) begin
                busy <= 1'b0; data_output <= mem[caddr]; cst <= C_IDLE;
              end else ccnt <= ccnt - 1;
        C_WR: if (ccnt == 0) begin
                busy <= 1'b0; cst <= C_IDLE;
              end else ccnt <= ccnt - 1;
        default: cst <= C_IDLE;
      endcase
    end
  end

  // ---------------- response / protocol monitor ----------------
  logic [17:0] rsps [$];
  int excl_viol = 0;
  int rd_en_hi  = 0;

  always @(negedge clk) begin
    if (rsp_valid) rsps.push_back({rsp_err, rsp_we, rsp_rdata});
    if (rd_enable && wr_enable) excl_viol++;
    if (rd_enable) rd_en_hi++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic we, input logic [23:0] a, input logic [15:0] d);
    int w = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    while (!req_ready && w < 300) begin @(negedge clk); w++; end
    if (!req_ready) check("push_stall", 32'd0, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic expect_rsp(input string tag, input logic we, input logic [15:0] rd, input logic err);
    int w = 0;
    logic [17:0] r;
    while (rsps.size() == 0 && w < 500) begin @(negedge clk); #1; w++; end
    if (rsps.size() == 0) check({tag, "_missing"}, 32'd0, 32'd1);
    else begin
      r = rsps.pop_front();
      check({tag, "_we"},    32'(r[16]),   32'(we));
      check({tag, "_rdata"}, 32'(r[15:0]), 32'(rd));
      check({tag, "_err"},   32'(r[17]),   32'(err));
    end
  endtask

  initial begin
    int rc, en0, w;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rd_en",     32'(rd_enable), 0);
    check("rst_wr_en",     32'(wr_enable), 0);
    check("rst_haddr",     32'(haddr), 0);
    check("rst_ready",     32'(req_ready), 1);
    check("rst_level",     32'(fifo_level), 0);
    check("rst_err",       32'(rsp_err), 0);
    @(negedge clk); rst = 1'b0;

    // 1: write issued while controller still in INIT
    push(1'b1, 24'h000123, 16'hBEEF);
    repeat (4) @(negedge clk);
    check("t1_wr_en_held", 32'(wr_enable), 1);
    check("t1_rd_en_low",  32'(rd_enable), 0);
    check("t1_haddr",      32'(haddr), 32'h123);
    check("t1_din",        32'(data_input), 32'hBEEF);
    check("t1_not_yet",    32'(wr_count), 0);
    expect_rsp("t1", 1'b1, 16'h0000, 1'b0);
    check("t1_wr_count",   32'(wr_count), 1);
    check("t1_mem",        32'(mem[8'h23]), 32'hBEEF);

    // 2: write then read same address
    push(1'b1, 24'h0A5A5A, 16'h1234);
    push(1'b0, 24'h0A5A5A, 16'h0000);
    expect_rsp("t2w", 1'b1, 16'h0000, 1'b0);
    expect_rsp("t2r", 1'b0, 16'h1234, 1'b0);

    // 3: fill the queue while the first request is stuck behind a refresh
    @(negedge clk); ref_req++;
    push(1'b1, 24'h40, 16'h5000);
    push(1'b1, 24'h41, 16'h5001);
    push(1'b1, 24'h42, 16'h5002);
    push(1'b1, 24'h43, 16'h5003);
    push(1'b0, 24'h41, 16'h0000);
    @(negedge clk);
    check("t3_level_full", 32'(fifo_level), 4);
    check("t3_ready_low",  32'(req_ready), 0);
    push(1'b0, 24'h43, 16'h0000);
    expect_rsp("t3_0", 1'b1, 16'h1234, 1'b0);
    expect_rsp("t3_1", 1'b1, 16'h1234, 1'b0);
    expect_rsp("t3_2", 1'b1, 16'h1234, 1'b0);
    expect_rsp("t3_3", 1'b1, 16'h1234, 1'b0);
    expect_rsp("t3_4", 1'b0, 16'h5001, 1'b0);
    expect_rsp("t3_5", 1'b0, 16'h5003, 1'b0);

    // 4: read enable held across REFRESH, executed exactly once
    repeat (2) @(negedge clk);
    ref_req++;
    rc = rd_count;
    push(1'b0, 24'h0A5A5A, 16'h0000);
    repeat (6) @(negedge clk);
    check("t4_rd_en_held", 32'(rd_enable), 1);
    check("t4_not_yet",    32'(rd_count), 32'(rc));
    expect_rsp("t4", 1'b0, 16'h1234, 1'b0);
    repeat (10) @(negedge clk);
    check("t4_one_read",   32'(rd_count), 32'(rc + 1));
    check("t4_no_extra",   32'(rsps.size()), 0);

    // 5: reset during S_WAIT drops everything
    push(1'b1, 24'h77, 16'hAAAA);
    push(1'b1, 24'h78, 16'h5555);
    w = 0;
    while (!(busy && !wr_enable) && w < 100) begin @(negedge clk); w++; end
    check("t5_reached_wait", 32'(busy && !wr_enable), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("t5_rsp_valid", 32'(rsp_valid), 0);
    check("t5_wr_en",     32'(wr_enable), 0);
    check("t5_haddr",     32'(haddr), 0);
    check("t5_din",       32'(data_input), 0);
    check("t5_rdata",     32'(rsp_rdata), 0);
    check("t5_rsp_we",    32'(rsp_we), 0);
    check("t5_level",     32'(fifo_level), 0);
    check("t5_ready",     32'(req_ready), 1);
    @(negedge clk); rst = 1'b0;
    repeat (40) @(negedge clk);
    check("t5_no_rsp",    32'(rsps.size()), 0);

`ifdef SDRAM_BRIDGE_TIMEOUT_EN
    // 6: controller never answers -> watchdog response, then next request proceeds
    dead = 1'b1;
    en0 = rd_en_hi;
    push(1'b0, 24'h0A5A5A, 16'h0000);
    expect_rsp("t6_tmo", 1'b0, 16'h0000, 1'b1);
    check("t6_en_cycles", 32'(rd_en_hi - en0), 16);
    dead = 1'b0;
    push(1'b0, 24'h0A5A5A, 16'h0000);
    expect_rsp("t6_next", 1'b0, 16'h1234, 1'b0);
`else
    en0 = 0;
`endif

    check("rd_wr_exclusive", 32'(excl_viol), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
